// File: rtl/frame_sync_pkg.sv
// Shared constants for the frame sync double buffer, plus a helper that builds the
// offscreen reset image (obstacle x/y pairs parked offscreen, player centred, mode 0).
package frame_sync_pkg;

    localparam int NCH_DEF   = 42;
    localparam int W_DEF     = 10;
    localparam int CNT_W_DEF = 16;

    localparam int X_OFF     = 700;
    localparam int Y_OFF     = 500;
    localparam int PLAYER_Y0 = 240;

    // Channels 0..NCH-3 are obstacle x/y pairs, NCH-2 is player_y, NCH-1 is gamemode.
    function automatic logic [NCH_DEF*W_DEF-1:0] build_rst_image();
        logic [NCH_DEF*W_DEF-1:0] img;
        img = '0;
        for (int i = 0; i < NCH_DEF - 2; i++) begin
            img[i*W_DEF +: W_DEF] = (i % 2 == 0) ? W_DEF'(X_OFF) : W_DEF'(Y_OFF);
        end
        img[(NCH_DEF-2)*W_DEF +: W_DEF] = W_DEF'(PLAYER_Y0);
        return img;
    endfunction

endpackage

// File: rtl/frame_sync_buffer_vs_edge_det.sv
// Vertical-sync edge detector: flags the first cycle vs enters (or leaves) its active level.
module vs_edge_det #(
    parameter bit VS_ACT_LOW  = 1'b1,
    parameter bit SWAP_ON_END = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic vs,
    output logic swap_evt
);

    localparam logic VS_ACT = VS_ACT_LOW ? 1'b0 : 1'b1;

    logic vs_d;
    logic vs_q;
    logic act_now;
    logic act_prev;

    always_comb begin
        vs_d = vs;
    end

    // Loading the active level means vs already active at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q <= VS_ACT;
        end else begin
            vs_q <= vs_d;
        end
    end

    assign act_now  = (vs == VS_ACT);
    assign act_prev = (vs_q == VS_ACT);
    assign swap_evt = SWAP_ON_END ? (act_prev & ~act_now) : (act_now & ~act_prev);

endmodule

// File: rtl/frame_sync_buffer.sv
// Tear-free shadow/active double buffer that swaps on a vsync edge.
// Optional drop/repeat frame statistics are built when FRAME_STATS_EN is defined.
module frame_sync_buffer
    import frame_sync_pkg::*;
#(
    parameter int               NCH         = NCH_DEF,
    parameter int               W           = W_DEF,
    parameter logic [NCH*W-1:0] RST_VAL     = '0,
    parameter bit               VS_ACT_LOW  = 1'b1,
    parameter bit               SWAP_ON_END = 1'b0,
    parameter bit               OVERWRITE   = 1'b1,
    parameter int               CNT_W       = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vs,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [NCH*W-1:0]   wr_data,
    output logic [NCH*W-1:0]   rd_data,
    output logic               pending,
    output logic               swap_pulse,
    output logic [CNT_W-1:0]   frame_cnt
`ifdef FRAME_STATS_EN
    ,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic [CNT_W-1:0]   repeat_cnt
`endif
);

    logic             swap_evt;
    logic             accept;
    logic             do_swap;
    logic [NCH*W-1:0] shadow_d, shadow_q;
    logic [NCH*W-1:0] active_d, active_q;
    logic             pending_d, pending_q;
    logic             swap_pulse_d, swap_pulse_q;
    logic [CNT_W-1:0] frame_cnt_d, frame_cnt_q;

    vs_edge_det #(
        .VS_ACT_LOW  (VS_ACT_LOW),
        .SWAP_ON_END (SWAP_ON_END)
    ) u_vs_edge (
        .clk      (clk),
        .rst      (rst),
        .vs       (vs),
        .swap_evt (swap_evt)
    );

    // In stall mode a new snapshot may slip in on the very cycle the pending one swaps out.
    assign wr_ready = OVERWRITE ? 1'b1 : (~pending_q | swap_evt);
    assign accept   = wr_valid & wr_ready;
    assign do_swap  = swap_evt & pending_q;

    always_comb begin
        shadow_d     = accept ? wr_data : shadow_q;
        active_d     = do_swap ? shadow_q : active_q;
        pending_d    = accept | (pending_q & ~do_swap);
        swap_pulse_d = do_swap;
        frame_cnt_d  = frame_cnt_q + CNT_W'(do_swap);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q     <= RST_VAL;
            active_q     <= RST_VAL;
            pending_q    <= 1'b0;
            swap_pulse_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            swap_pulse_q <= swap_pulse_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign rd_data    = active_q;
    assign pending    = pending_q;
    assign swap_pulse = swap_pulse_q;
    assign frame_cnt  = frame_cnt_q;

`ifdef FRAME_STATS_EN
    logic [CNT_W-1:0] drop_cnt_d, drop_cnt_q;
    logic [CNT_W-1:0] repeat_cnt_d, repeat_cnt_q;

    always_comb begin
        drop_cnt_d   = drop_cnt_q + CNT_W'(OVERWRITE & accept & pending_q & ~swap_evt);
        repeat_cnt_d = repeat_cnt_q + CNT_W'(swap_evt & ~pending_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q   <= '0;
            repeat_cnt_q <= '0;
        end else begin
            drop_cnt_q   <= drop_cnt_d;
            repeat_cnt_q <= repeat_cnt_d;
        end
    end

    assign drop_cnt   = drop_cnt_q;
    assign repeat_cnt = repeat_cnt_q;
`endif

endmodule
